// File: rtl/test_value_display_if.sv
// Display-side bundle of test_value_display: the value to show and the
// multiplexed seven-segment drive lines.
interface test_value_display_if;
   logic [15:0] test_value;
   logic [3:0]  an_n;
   logic [6:0]  seg_n;
   logic        dp_n;
   logic        frame_done;

   // Signals are level-based: there is no valid/ready handshake. test_value is
   // sampled only on the clock edge where frame_done rises; an_n/seg_n/dp_n are
   // registered board-level drive lines.
   modport master (
      output test_value,
      input  an_n,
      input  seg_n,
      input  dp_n,
      input  frame_done
   );

   modport slave (
      input  test_value,
      output an_n,
      output seg_n,
      output dp_n,
      output frame_done
   );
endinterface

// File: rtl/test_value_display.sv
// Four-digit multiplexed common-anode seven-segment driver for a 16-bit value,
// with frame-aligned snapshots, per-slot blanking and optional leading-zero blank.
module test_value_display #(
   parameter int REFRESH_DIV  = 50000,
   parameter int BLANK_CYCLES = 4,
   parameter bit LZ_BLANK     = 1'b0
) (
   input  logic             clk_in,
   input  logic             rst_in,
   test_value_display_if.slave disp
);

   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);

   logic [CW-1:0] cnt;
   logic [1:0]    idx;
   logic [15:0]   value_q;
   logic [3:0]    an_q;
   logic [6:0]    seg_q;
   logic          frame_done_q;

   logic          tick;
   logic          frame_edge;
   logic [3:0]    nibble;
   logic          lz_hit;
   logic          blank;
   logic [3:0]    an_next;
   logic [6:0]    seg_next;

   function automatic logic [6:0] hex7(input logic [3:0] h);
      logic [6:0] s;
      case (h)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   assign tick       = (cnt == CNT_LAST);
   assign frame_edge = tick && (idx == 2'd3);

   always_comb begin
      nibble = value_q[{idx, 2'b00} +: 4];
      // A digit is a leading zero when it and every more significant digit are 0.
      case (idx)
         2'd1:    lz_hit = (value_q[15:4]  == 12'h000);
         2'd2:    lz_hit = (value_q[15:8]  == 8'h00);
         2'd3:    lz_hit = (value_q[15:12] == 4'h0);
         default: lz_hit = 1'b0;
      endcase
      blank = (cnt < CNT_BLANK) || (LZ_BLANK && lz_hit);
      if (blank) begin
         an_next  = 4'b1111;
         seg_next = 7'h7F;
      end else begin
         an_next  = ~(4'b0001 << idx);
         seg_next = hex7(nibble);
      end
   end

   // Outputs are computed from the pre-edge scan state, giving one clock of lag.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         cnt          <= '0;
         idx          <= 2'd0;
         value_q      <= 16'h0000;
         an_q         <= 4'b1111;
         seg_q        <= 7'h7F;
         frame_done_q <= 1'b0;
      end else begin
         an_q         <= an_next;
         seg_q        <= seg_next;
         frame_done_q <= frame_edge;
         if (tick) begin
            cnt <= '0;
            idx <= idx + 2'd1;
            if (frame_edge) value_q <= disp.test_value;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   assign disp.an_n       = an_q;
   assign disp.seg_n      = seg_q;
   assign disp.dp_n       = 1'b1;
   assign disp.frame_done = frame_done_q;

endmodule

// File: tb/tb_test_value_display.sv
// Bench for test_value_display: cycle-level reference model plus table vectors
// and hand sequences for reset, tear-free snapshot, leading-zero blank and timing.
module tb_test_value_display;

   localparam int RD = 8;
   localparam int BC = 2;
   localparam int FRAME = 4 * RD;

   logic clk;
   logic rst;
   logic [15:0] tv;

   int checks;
   int failures;

   test_value_display_if if0 ();
   test_value_display_if if1 ();

   assign if0.test_value = tv;
   assign if1.test_value = tv;

   test_value_display #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC), .LZ_BLANK(1'b0)) dut0 (
      .clk_in(clk), .rst_in(rst), .disp(if0)
   );
   test_value_display #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC), .LZ_BLANK(1'b1)) dut1 (
      .clk_in(clk), .rst_in(rst), .disp(if1)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [6:0] seg_lut [16];
   initial begin
      seg_lut = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
   end

   // Expected {an_n, seg_n} for a given shown value and clocks-since-reset.
   function automatic logic [10:0] exp_out(input logic [15:0] v, input int s, input bit lz);
      int p, d, c;
      logic [15:0] upper;
      bit off;
      p = s % FRAME;
      d = p / RD;
      c = p % RD;
      upper = v >> (4 * d);
      off = (c < BC) || (lz && d > 0 && upper == 16'h0000);
      if (off) return {4'b1111, 7'h7F};
      return {~(4'b0001 << d), seg_lut[upper[3:0]]};
   endfunction

   // Reference model: snapshot on the last clock of every 32-clock frame.
   int          m_s;
   logic [15:0] m_val;
   logic [10:0] e0, e1;
   logic        e_fd;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_s   <= 0;
         m_val <= 16'h0000;
         e0    <= 11'h7FF;
         e1    <= 11'h7FF;
         e_fd  <= 1'b0;
      end else begin
         e0   <= exp_out(m_val, m_s, 1'b0);
         e1   <= exp_out(m_val, m_s, 1'b1);
         e_fd <= (m_s % FRAME == FRAME - 1);
         if (m_s % FRAME == FRAME - 1) m_val <= tv;
         m_s  <= m_s + 1;
      end
   end

   // scoreboard
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         chk("model_lz0", {21'd0, if0.an_n, if0.seg_n, if0.frame_done, if0.dp_n},
             {21'd0, e0, e_fd, 1'b1});
         chk("model_lz1", {21'd0, if1.an_n, if1.seg_n, if1.frame_done, if1.dp_n},
             {21'd0, e1, e_fd, 1'b1});
      end
   end

   // driver helpers
   task automatic wait_fd();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (if0.frame_done !== 1'b1 && n < FRAME + 8);
      if (if0.frame_done !== 1'b1) chk("wait_frame_done_timeout", 32'd0, 32'd1);
   endtask

   task automatic chk_reset_outputs(input string name);
      chk({name, "_an0"},  {28'd0, if0.an_n},  32'hF);
      chk({name, "_seg0"}, {25'd0, if0.seg_n}, 32'h7F);
      chk({name, "_fd0"},  {31'd0, if0.frame_done}, 32'd0);
      chk({name, "_an1"},  {28'd0, if1.an_n},  32'hF);
      chk({name, "_seg1"}, {25'd0, if1.seg_n}, 32'h7F);
   endtask

   typedef struct {
      logic [15:0] value;
      bit          lz;
      int          idx;
      logic [3:0]  an;
      logic [6:0]  seg;
   } vec_t;

   vec_t vecs [10];

   initial begin
      int n, lit;
      checks = 0;
      failures = 0;

      vecs[0] = '{16'h12AF, 1'b0, 0, 4'b1110, 7'h0E};
      vecs[1] = '{16'h12AF, 1'b0, 1, 4'b1101, 7'h08};
      vecs[2] = '{16'h12AF, 1'b0, 2, 4'b1011, 7'h24};
      vecs[3] = '{16'h12AF, 1'b0, 3, 4'b0111, 7'h79};
      vecs[4] = '{16'h0005, 1'b1, 0, 4'b1110, 7'h12};
      vecs[5] = '{16'h0005, 1'b1, 1, 4'b1111, 7'h7F};
      vecs[6] = '{16'h0005, 1'b1, 3, 4'b1111, 7'h7F};
      vecs[7] = '{16'h0000, 1'b1, 0, 4'b1110, 7'h40};
      vecs[8] = '{16'h0000, 1'b1, 2, 4'b1111, 7'h7F};
      vecs[9] = '{16'h0500, 1'b1, 1, 4'b1101, 7'h40};

      rst = 1'b1;
      tv  = 16'h0000;
      #3;
      chk_reset_outputs("reset_initial");
      chk("reset_dp", {31'd0, if0.dp_n}, 32'd1);

      // mid-slot reset, then scan restart and first-frame timing
      @(negedge clk);
      rst = 1'b0;
      repeat (13) @(negedge clk);
      #2 rst = 1'b1;
      #1 chk_reset_outputs("reset_midslot");
      @(negedge clk);
      rst = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (n == 2) chk("restart_blank_an", {28'd0, if0.an_n}, 32'hF);
         if (n == 3) chk("restart_digit0", {21'd0, if0.an_n, if0.seg_n}, {21'd0, 4'b1110, 7'h40});
         if (n == 3) chk("restart_digit0_lz", {21'd0, if1.an_n, if1.seg_n}, {21'd0, 4'b1110, 7'h40});
      end while (if0.frame_done !== 1'b1 && n < 100);
      chk("first_fd_latency", n, FRAME);
      @(negedge clk);
      chk("fd_width", {31'd0, if0.frame_done}, 32'd0);
      n = 1;
      while (if0.frame_done !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("fd_period", n, FRAME);

      // table vectors
      for (int i = 0; i < 10; i++) begin
         tv = vecs[i].value;
         wait_fd();
         repeat (5 + RD * vecs[i].idx) @(negedge clk);
         if (vecs[i].lz)
            chk($sformatf("vec%0d", i), {21'd0, if1.an_n, if1.seg_n}, {21'd0, vecs[i].an, vecs[i].seg});
         else
            chk($sformatf("vec%0d", i), {21'd0, if0.an_n, if0.seg_n}, {21'd0, vecs[i].an, vecs[i].seg});
      end

      // 2 dark clocks then 6 lit clocks per slot
      tv = 16'h12AF;
      wait_fd();
      lit = 0;
      for (int k = 0; k < RD; k++) begin
         @(negedge clk);
         if (k < BC) chk("slot_dark", {28'd0, if0.an_n}, 32'hF);
         if (if0.an_n == 4'b1110) lit++;
      end
      chk("slot_lit_count", lit, RD - BC);

      // tear-free snapshot
      wait_fd();
      repeat (2) @(negedge clk);
      tv = 16'h3456;
      repeat (27) @(negedge clk);
      chk("tear_old_digit3", {21'd0, if0.an_n, if0.seg_n}, {21'd0, 4'b0111, 7'h79});
      wait_fd();
      repeat (5) @(negedge clk);
      chk("tear_new_digit0", {21'd0, if0.an_n, if0.seg_n}, {21'd0, 4'b1110, 7'h02});

      // randomized values checked by the model
      for (int k = 0; k < 1200; k++) begin
         @(negedge clk);
         if ($urandom_range(0, 15) == 0) begin
            case ($urandom_range(0, 3))
               0: tv = 16'($urandom_range(0, 15));
               1: tv = 16'($urandom_range(0, 255));
               default: tv = 16'($urandom);
            endcase
         end
      end

      repeat (4) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
